// File: rtl/logical_pkg.sv
// rtl/logical_pkg.sv - op codes, FSM states and operand widths for logical_arbiter
package logical_pkg;

  localparam int XY_W  = 4;
  localparam int Z_W   = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } opT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } stateT;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/logical_arbiter_rr_arbiter2.sv
// rtl/logical_arbiter_rr_arbiter2.sv - two-way round-robin grant
// A tie goes to the requester that was not granted last time.
module rr_arbiter2
  import logical_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic lastGrant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      grant0 = lastGrant;
      grant1 = !lastGrant;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

endmodule

// File: rtl/logical_arbiter.sv
// rtl/logical_arbiter.sv - shares one logical unit between two requesters
// Optional grant statistics under LOGICAL_ARB_STATS_EN.
module logical_arbiter
  import logical_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [XY_W-1:0]  req0X,
  input  logic [XY_W-1:0]  req0Y,
  input  logic [Z_W-1:0]   req0Z,
  input  logic [1:0]       req0Op,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [XY_W-1:0]  req1X,
  input  logic [XY_W-1:0]  req1Y,
  input  logic [Z_W-1:0]   req1Z,
  input  logic [1:0]       req1Op,
  output logic [XY_W-1:0]  luX,
  output logic [XY_W-1:0]  luY,
  output logic [Z_W-1:0]   luZ,
  output logic [1:0]       luOp,
  input  logic [Z_W-1:0]   luResult,
  output logic [Z_W-1:0]   result,
  output logic             resultValid,
  output logic             resultOwner,
  input  logic             resultReady
`ifdef LOGICAL_ARB_STATS_EN
  ,
  output logic [7:0]       grantCount0,
  output logic [7:0]       grantCount1
`endif
);

  stateT            state;
  stateT            stateNext;
  logic             lastGrant;
  logic [CNT_W-1:0] cycleCnt;
  logic [XY_W-1:0]  xReg;
  logic [XY_W-1:0]  yReg;
  logic [Z_W-1:0]   zReg;
  opT               opReg;
  logic             ownerReg;
  logic             grant0;
  logic             grant1;
  logic             fire0;
  logic             fire1;
  logic             fire;
  logic             lastExec;

  rr_arbiter2 uArb (
    .valid0    (req0Valid),
    .valid1    (req1Valid),
    .lastGrant (lastGrant),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // Ready is masked during reset so no requester sees a transfer that is discarded.
  assign req0Ready = resetN && (state == IDLE) && grant0;
  assign req1Ready = resetN && (state == IDLE) && grant1;
  assign fire0     = req0Valid && req0Ready;
  assign fire1     = req1Valid && req1Ready;
  assign fire      = fire0 || fire1;
  assign lastExec  = (cycleCnt == CNT_W'(EXEC_CYCLES - 1));

  assign luX         = xReg;
  assign luY         = yReg;
  assign luZ         = zReg;
  assign luOp        = opReg;
  assign resultValid = (state == RESP);
  assign resultOwner = ownerReg;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (fire)        stateNext = EXEC;
      EXEC:    if (lastExec)    stateNext = RESP;
      RESP:    if (resultReady) stateNext = IDLE;
      default:                  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      cycleCnt  <= '0;
      xReg      <= '0;
      yReg      <= '0;
      zReg      <= '0;
      opReg     <= OP_AND;
      ownerReg  <= 1'b0;
      result    <= '0;
    end else begin
      state <= stateNext;
      if (fire) begin
        xReg     <= fire1 ? req1X : req0X;
        yReg     <= fire1 ? req1Y : req0Y;
        zReg     <= fire1 ? req1Z : req0Z;
        opReg    <= opT'(fire1 ? req1Op : req0Op);
        ownerReg <= fire1;
        cycleCnt <= '0;
      end else if ((state == EXEC) && !lastExec) begin
        cycleCnt <= cycleCnt + 1'b1;
      end
      if ((state == EXEC) && lastExec) begin
        result <= luResult;
      end
      if ((state == RESP) && resultReady) begin
        lastGrant <= ownerReg;
      end
    end
  end

`ifdef LOGICAL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      grantCount0 <= '0;
      grantCount1 <= '0;
    end else begin
      if (fire0) grantCount0 <= satInc8(grantCount0);
      if (fire1) grantCount1 <= satInc8(grantCount1);
    end
  end
`endif

endmodule

// File: tb/tb_logical_arbiter.sv
// tb/tb_logical_arbiter.sv - self-checking bench for logical_arbiter
// Instance a runs EXEC_CYCLES=1, instance b runs EXEC_CYCLES=4 on the same stimulus.
module tb_logical_arbiter;

  localparam int EC_A = 1;
  localparam int EC_B = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       req0Valid, req1Valid, resultReady;
  logic [3:0] req0X, req0Y, req1X, req1Y;
  logic [7:0] req0Z, req1Z;
  logic [1:0] req0Op, req1Op;

  logic       aReq0Ready, aReq1Ready, aResultValid, aResultOwner;
  logic [3:0] aLuX, aLuY;
  logic [7:0] aLuZ, aLuResult, aResult;
  logic [1:0] aLuOp;
  logic       bReq0Ready, bReq1Ready, bResultValid, bResultOwner;
  logic [3:0] bLuX, bLuY;
  logic [7:0] bLuZ, bLuResult, bResult;
  logic [1:0] bLuOp;
`ifdef LOGICAL_ARB_STATS_EN
  logic [7:0] aCnt0, aCnt1, bCnt0, bCnt1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] luModel(input logic [1:0] op, input logic [3:0] x,
                                         input logic [3:0] y, input logic [7:0] z);
    case (op)
      2'b00:   return {4'h0, x & y};
      2'b01:   return {4'h0, x | y};
      2'b10:   return {4'h0, x ^ y};
      default: return ~z;
    endcase
  endfunction

  assign aLuResult = luModel(aLuOp, aLuX, aLuY, aLuZ);
  assign bLuResult = luModel(bLuOp, bLuX, bLuY, bLuZ);

  logical_arbiter #(.EXEC_CYCLES(EC_A)) dutA (
    .clk(clk), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(aReq0Ready), .req0X(req0X), .req0Y(req0Y),
    .req0Z(req0Z), .req0Op(req0Op),
    .req1Valid(req1Valid), .req1Ready(aReq1Ready), .req1X(req1X), .req1Y(req1Y),
    .req1Z(req1Z), .req1Op(req1Op),
    .luX(aLuX), .luY(aLuY), .luZ(aLuZ), .luOp(aLuOp), .luResult(aLuResult),
    .result(aResult), .resultValid(aResultValid), .resultOwner(aResultOwner),
    .resultReady(resultReady)
`ifdef LOGICAL_ARB_STATS_EN
    , .grantCount0(aCnt0), .grantCount1(aCnt1)
`endif
  );

  logical_arbiter #(.EXEC_CYCLES(EC_B)) dutB (
    .clk(clk), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(bReq0Ready), .req0X(req0X), .req0Y(req0Y),
    .req0Z(req0Z), .req0Op(req0Op),
    .req1Valid(req1Valid), .req1Ready(bReq1Ready), .req1X(req1X), .req1Y(req1Y),
    .req1Z(req1Z), .req1Op(req1Op),
    .luX(bLuX), .luY(bLuY), .luZ(bLuZ), .luOp(bLuOp), .luResult(bLuResult),
    .result(bResult), .resultValid(bResultValid), .resultOwner(bResultOwner),
    .resultReady(resultReady)
`ifdef LOGICAL_ARB_STATS_EN
    , .grantCount0(bCnt0), .grantCount1(bCnt1)
`endif
  );

  task automatic randOperands;
    req0X = 4'($urandom); req0Y = 4'($urandom); req0Z = 8'($urandom); req0Op = 2'($urandom);
    req1X = 4'($urandom); req1Y = 4'($urandom); req1Z = 8'($urandom); req1Op = 2'($urandom);
  endtask

  task automatic doReset;
    @(negedge clk);
    resetN = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0; resultReady = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    randOperands();
    resetN = 1'b0; req0Valid = 1'b1; req1Valid = 1'b1; resultReady = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({aReq1Ready, aReq0Ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 00", {aReq1Ready, aReq0Ready});
    end
    vectors++;
    if ({aResultValid, aResultOwner, aResult} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_result: got v=%b o=%b r=%h expected 0 0 00", aResultValid, aResultOwner, aResult);
    end
    vectors++;
    if ({aLuX, aLuY, aLuZ, aLuOp} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_lu: got %h %h %h %b expected zeros", aLuX, aLuY, aLuZ, aLuOp);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    resetN = 1'b1;
  endtask

  task automatic test_known_vectors;
    logic       tWho [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] tOp  [3] = '{2'b00, 2'b11, 2'b10};
    logic [3:0] tX   [3] = '{4'hC, 4'h0, 4'hF};
    logic [3:0] tY   [3] = '{4'hA, 4'h0, 4'h5};
    logic [7:0] tZ   [3] = '{8'h00, 8'h3C, 8'h00};
    logic [7:0] tExp [3] = '{8'h08, 8'hC3, 8'h0A};
    int lat;
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randOperands();
      resultReady = 1'b0;
      req0Valid = !tWho[i]; req1Valid = tWho[i];
      if (tWho[i]) begin
        req1X = tX[i]; req1Y = tY[i]; req1Z = tZ[i]; req1Op = tOp[i];
      end else begin
        req0X = tX[i]; req0Y = tY[i]; req0Z = tZ[i]; req0Op = tOp[i];
      end
      #1;
      vectors++;
      if ({aReq1Ready, aReq0Ready} !== {tWho[i], !tWho[i]}) begin
        miscompares++;
        $display("FAIL known_ready[%0d]: got %b expected %b", i, {aReq1Ready, aReq0Ready}, {tWho[i], !tWho[i]});
      end
      lat = -1;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
        @(negedge clk);
        req0Valid = 1'b0; req1Valid = 1'b0;
        #1;
        if (aResultValid === 1'b1) lat = c;
      end
      vectors++;
      if (lat != EC_A + 1) begin
        miscompares++; $display("FAIL known_latency[%0d]: got %0d expected %0d", i, lat, EC_A + 1);
      end
      vectors++;
      if ({aResultOwner, aResult} !== {tWho[i], tExp[i]}) begin
        miscompares++;
        $display("FAIL known_result[%0d]: got o=%b r=%h expected o=%b r=%h", i, aResultOwner, aResult, tWho[i], tExp[i]);
      end
      @(negedge clk); resultReady = 1'b1;
      @(negedge clk); resultReady = 1'b0;
    end
  endtask

  task automatic test_alternate;
    int nGrants = 0;
    logic [1:0] rdy;
    doReset();
    @(negedge clk);
    randOperands();
    req0Valid = 1'b1; req1Valid = 1'b1; resultReady = 1'b1;
    for (int c = 0; c < 40 && nGrants < 4; c++) begin
      #1;
      rdy = {aReq1Ready, aReq0Ready};
      if (rdy != 2'b00) begin
        vectors++;
        if (rdy !== ((nGrants % 2 == 0) ? 2'b01 : 2'b10)) begin
          miscompares++; $display("FAIL alternate[%0d]: got ready %b", nGrants, rdy);
        end
        nGrants++;
      end
      @(negedge clk);
    end
    vectors++;
    if (nGrants != 4) begin
      miscompares++; $display("FAIL alternate_count: got %0d expected 4", nGrants);
    end
    req0Valid = 1'b0; req1Valid = 1'b0; resultReady = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat = -1;
    doReset();
    @(negedge clk);
    randOperands();
    req1Valid = 1'b1; req1Op = 2'b01; req1X = 4'h5; req1Y = 4'hA;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk); #1;
      if (aResultValid === 1'b1) lat = c;
    end
    vectors++;
    if (lat != EC_A + 1) begin
      miscompares++; $display("FAIL bp_latency: got %0d expected %0d", lat, EC_A + 1);
    end
    req0Valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      randOperands();
      #1;
      vectors++;
      if ({aResultValid, aResultOwner, aResult, aReq1Ready, aReq0Ready} !== {1'b1, 1'b1, 8'h0F, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b o=%b r=%h rdy=%b expected 1 1 0f 00",
                 c, aResultValid, aResultOwner, aResult, {aReq1Ready, aReq0Ready});
      end
    end
    @(negedge clk); resultReady = 1'b1;
    @(negedge clk); resultReady = 1'b0; #1;
    vectors++;
    if ({aResultValid, aReq1Ready, aReq0Ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=01", aResultValid, {aReq1Ready, aReq0Ready});
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  task automatic test_random;
    logic        mLast = 1'b1;
    logic [17:0] mLu = '0;
    doReset();
    for (int n = 0; n < 80; n++) begin
      int         v;
      int         hold;
      logic       g;
      logic [7:0] expRes;
      @(negedge clk);
      resultReady = 1'b0;
      v = $urandom_range(0, 3);
      req0Valid = v[0]; req1Valid = v[1];
      randOperands();
      #1;
      if (v == 0) begin
        vectors++;
        if ({aReq1Ready, aReq0Ready, aResultValid, aLuX, aLuY, aLuZ, aLuOp} !== {3'b000, mLu}) begin
          miscompares++; $display("FAIL rand_idle n=%0d: got rdy=%b lu=%h expected 00 %h",
                                  n, {aReq1Ready, aReq0Ready}, {aLuX, aLuY, aLuZ, aLuOp}, mLu);
        end
        continue;
      end
      g = (v == 3) ? !mLast : v[1];
      vectors++;
      if ({aReq1Ready, aReq0Ready} !== {g, !g}) begin
        miscompares++; $display("FAIL rand_grant n=%0d: got %b expected %b", n, {aReq1Ready, aReq0Ready}, {g, !g});
      end
      mLu    = g ? {req1X, req1Y, req1Z, req1Op} : {req0X, req0Y, req0Z, req0Op};
      expRes = g ? luModel(req1Op, req1X, req1Y, req1Z) : luModel(req0Op, req0X, req0Y, req0Z);
      for (int c = 0; c < EC_A; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          req0Valid = 1'b0; req1Valid = 1'b0;
        end
        randOperands();
        #1;
        vectors++;
        if ({aResultValid, aReq1Ready, aReq0Ready, aLuX, aLuY, aLuZ, aLuOp} !== {3'b000, mLu}) begin
          miscompares++; $display("FAIL rand_exec n=%0d: got v=%b rdy=%b lu=%h expected 0 00 %h",
                                  n, aResultValid, {aReq1Ready, aReq0Ready}, {aLuX, aLuY, aLuZ, aLuOp}, mLu);
        end
      end
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        @(negedge clk);
        req0Valid = 1'($urandom); req1Valid = 1'($urandom);
        resultReady = (c == hold);
        #1;
        vectors++;
        if ({aResultValid, aResultOwner, aResult, aReq1Ready, aReq0Ready} !== {1'b1, g, expRes, 2'b00}) begin
          miscompares++; $display("FAIL rand_resp n=%0d: got v=%b o=%b r=%h rdy=%b expected 1 %b %h 00",
                                  n, aResultValid, aResultOwner, aResult, {aReq1Ready, aReq0Ready}, g, expRes);
        end
      end
      mLast = g;
    end
    @(negedge clk);
    req0Valid = 1'b0; req1Valid = 1'b0; resultReady = 1'b0;
  endtask

  task automatic test_exec_reset;
    int lat = -1;
    int spurious = 0;
    doReset();
    @(negedge clk);
    randOperands();
    req0Valid = 1'b1; req0Op = 2'b00; req0X = 4'hC; req0Y = 4'hA;
    #1;
    vectors++;
    if (bReq0Ready !== 1'b1) begin
      miscompares++; $display("FAIL exec4_ready: got %b expected 1", bReq0Ready);
    end
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      req0Valid = 1'b0;
      #1;
      if (bResultValid === 1'b1) lat = c;
    end
    vectors++;
    if (lat != EC_B + 1 || bResult !== 8'h08) begin
      miscompares++; $display("FAIL exec4_latency: got %0d r=%h expected %0d r=08", lat, bResult, EC_B + 1);
    end
    @(negedge clk); resultReady = 1'b1;
    @(negedge clk); resultReady = 1'b0;
    req1Valid = 1'b1; req1Op = 2'b11; req1Z = 8'h3C;
    #1;
    vectors++;
    if (bReq1Ready !== 1'b1) begin
      miscompares++; $display("FAIL exec4_ready2: got %b expected 1", bReq1Ready);
    end
    @(negedge clk); req1Valid = 1'b0;
    @(negedge clk); resetN = 1'b0; req1Valid = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({bResultValid, bResultOwner, bResult, bReq1Ready, bReq0Ready, bLuX, bLuY, bLuZ, bLuOp} !== 30'h0) begin
      miscompares++; $display("FAIL exec4_abort: got v=%b o=%b r=%h rdy=%b lu=%h expected all zero",
                              bResultValid, bResultOwner, bResult, {bReq1Ready, bReq0Ready},
                              {bLuX, bLuY, bLuZ, bLuOp});
    end
    resetN = 1'b1; req1Valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (bResultValid !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++; $display("FAIL exec4_no_result: got %0d valid cycles expected 0", spurious);
    end
  endtask

`ifdef LOGICAL_ARB_STATS_EN
  task automatic test_stats;
    doReset();
    @(negedge clk);
    randOperands();
    req0Valid = 1'b1; resultReady = 1'b1;
    // a: 3 cycles per transfer -> 300; b: 6 cycles per transfer -> 150
    repeat (900) @(negedge clk);
    #1;
    vectors++;
    if ({aCnt0, aCnt1} !== {8'hFF, 8'h00}) begin
      miscompares++; $display("FAIL stats_a: got %h %h expected ff 00", aCnt0, aCnt1);
    end
    vectors++;
    if ({bCnt0, bCnt1} !== {8'd150, 8'h00}) begin
      miscompares++; $display("FAIL stats_b: got %h %h expected 96 00", bCnt0, bCnt1);
    end
    req0Valid = 1'b0; resultReady = 1'b0;
  endtask
`endif

  initial begin
    resetN = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0; resultReady = 1'b0;
    req0X = '0; req0Y = '0; req0Z = '0; req0Op = '0;
    req1X = '0; req1Y = '0; req1Z = '0; req1Op = '0;
    test_reset();
    test_known_vectors();
    test_alternate();
    test_backpressure();
    test_random();
    test_exec_reset();
`ifdef LOGICAL_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logical_arbiter.md
LOGICAL_ARBITER -- requirements
Module: logical_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, meaning cycles operands are held on the shared unit before capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetN  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req0Valid / req1Valid  input  1  requester n has a command.
REQ-005 req0Ready / req1Ready  output  1  command of requester n accepted this cycle.
REQ-006 req0X, req1X / req0Y, req1Y  input  4  operands for AND/OR/XOR.
REQ-007 req0Z / req1Z  input  8  operand for NOT.
REQ-008 req0Op / req1Op  input  2  operation code.
REQ-009 luX  output  4; luY  output  4; luZ  output  8; luOp  output  2: drive the shared logical unit.
REQ-010 luResult  input  8  combinational result of the shared logical unit.
REQ-011 result  output  8  captured result.
REQ-012 resultValid  output  1; resultOwner  output  1 (0 = req0, 1 = req1); resultReady  input  1.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and RESP.
REQ-014 IDLE: one valid -> grant it; both valid -> grant the requester not granted last (lastGrant pointer).
REQ-015 reqNReady SHALL be asserted combinationally, only in IDLE, only for the granted requester; a transfer occurs when valid and ready are both high.
REQ-016 On transfer: latch X/Y/Z/Op and owner into internal registers, clear the cycle counter, go to EXEC.
REQ-017 lu* outputs SHALL always reflect the latched registers; they change only on a transfer.
REQ-018 EXEC: count EXEC_CYCLES cycles; on the last one capture luResult into result and go to RESP.
REQ-019 RESP: resultValid = 1 and resultOwner = latched owner; when resultReady = 1, update lastGrant to the owner and go to IDLE.
REQ-020 Latency: transfer at cycle T -> resultValid first high at T+EXEC_CYCLES+1.
REQ-021 result, resultOwner and resultValid SHALL be held stable while resultValid = 1 and resultReady = 0.
REQ-022 No new command is accepted outside IDLE; requesters hold valid. Valid dropped after transfer has no effect.
REQ-023 Op encoding: 00 AND, 01 OR, 10 XOR, 11 NOT. Results of 4-bit ops are zero-extended by the unit; the block does not modify luResult.

Reset
REQ-024 resetN = 0 SHALL force: state IDLE, lastGrant = 1 (req0 wins first tie), counter 0, latched operands 0, luOp 00, result 8'h00, resultValid 0, resultOwner 0, both ready 0.
REQ-025 Reset in EXEC or RESP SHALL abort the command with no result delivered; stats counters (REQ-026) also clear.

Configuration
REQ-026 With LOGICAL_ARB_STATS_EN defined: outputs grantCount0 and grantCount1 (8 bits each) increment on each transfer of that requester and saturate at 8'hFF.
REQ-027 Without LOGICAL_ARB_STATS_EN: those ports and counters are absent, and all other behaviour is identical.

Structure
REQ-028 Shared package logical_pkg: op codes (OP_AND, OP_OR, OP_XOR, OP_NOT), state encoding, and operand widths 4 and 8.
REQ-029 Sub-module rr_arbiter2: two-way round-robin grant from two valid signals plus lastGrant. The FSM, registers and counters stay in logical_arbiter.

Verification
REQ-030 With EXEC_CYCLES = 1, req0 AND x=4'hC y=4'hA -> result 8'h08, owner 0, resultValid 2 cycles after transfer.
REQ-031 req1 NOT z=8'h3C -> result 8'hC3, owner 1. req0 XOR x=4'hF y=4'h5 -> 8'h0A.
REQ-032 After reset, both valid continuously with resultReady = 1 -> grants alternate req0, req1, req0, req1.
REQ-033 resultReady held 0 for 5 cycles in RESP -> result and owner stable, no ready asserted, then IDLE one cycle after resultReady = 1.
REQ-034 resetN = 0 during EXEC with EXEC_CYCLES = 4 -> next cycle all outputs at reset values, no resultValid pulse.
REQ-035 With LOGICAL_ARB_STATS_EN, 300 req0 transfers -> grantCount0 = 8'hFF and grantCount1 = 0.
